// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state,
// default geometry and the one-hot write-enable decoder.
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;

    // Decoder is sized for the largest supported file; callers truncate to NUM_REGS.
    localparam int DEC_ADDR_W = 8;
    localparam int DEC_W      = 1 << DEC_ADDR_W;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

    function automatic logic [DEC_W-1:0] onehot_dec(input logic [DEC_ADDR_W-1:0] addr);
        logic [DEC_W-1:0] vec;
        vec       = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write bus of the register file: decode/writeback side is the master,
// the register file is the slave.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_PORTS = 3
);
    logic [RD_PORTS*ADDR_W-1:0] rd_addr;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic                       wr0_en;
    logic [ADDR_W-1:0]          wr0_addr;
    logic [DATA_W-1:0]          wr0_data;
    logic                       wr1_en;
    logic [ADDR_W-1:0]          wr1_addr;
    logic [DATA_W-1:0]          wr1_data;
    logic                       ready;
    logic                       wr_clash;
    logic                       wr_drop;
    logic                       err_clr;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, err_clr,
        input  rd_data, ready, wr_clash, wr_drop
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, err_clr,
        output rd_data, ready, wr_clash, wr_drop
    );

endinterface

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: walks every register index once, then raises ready.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int CNT_W    = ADDR_W + 1;

    rf_state_t        state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? RF_CLEAR : RF_RUN;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_REGS - 1)) begin
                        state <= RF_RUN;
                        ready <= 1'b1;
                    end
                end
                RF_RUN:  ready <= 1'b1;
                default: state <= RF_RUN;
            endcase
        end
    end

    // No clearing while reset is held, so each index is written exactly once.
    assign clr_en   = (state == RF_CLEAR) && !rst;
    assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports (port 1 wins on a clash), RD_PORTS
// combinational read ports with optional write bypass, sequential clear after reset.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int RD_PORTS       = 3,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  bus
);
    localparam int NUM_REGS = 1 << ADDR_W;

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready;

    reg_file_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    logic [NUM_REGS-1:0] clr_dec;
    logic [NUM_REGS-1:0] we0;
    logic [NUM_REGS-1:0] we1;

    assign clr_dec = clr_en ? NUM_REGS'(onehot_dec(DEC_ADDR_W'(clr_addr))) : '0;
    assign we0 = (ready && bus.wr0_en) ? NUM_REGS'(onehot_dec(DEC_ADDR_W'(bus.wr0_addr))) : '0;
    assign we1 = (ready && bus.wr1_en) ? NUM_REGS'(onehot_dec(DEC_ADDR_W'(bus.wr1_addr))) : '0;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // NOTE: the array has no reset branch; zeroing is the clear sequencer's job,
    // which keeps the storage mappable onto plain flops or RAM without a reset tree.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_dec[i])
                regs[i] <= '0;
            else if (we1[i])
                regs[i] <= bus.wr1_data;
            else if (we0[i])
                regs[i] <= bus.wr0_data;
        end
    end

    logic [RD_PORTS*DATA_W-1:0] rd_data_c;

    // NOTE: rd_data_c is given a full default first so every path assigns it and no latch is inferred.
    always_comb begin
        rd_data_c = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            rd_data_c[k*DATA_W +: DATA_W] = regs[bus.rd_addr[k*ADDR_W +: ADDR_W]];
            if ((BYPASS != 0) && ready) begin
                if (bus.wr0_en && (bus.wr0_addr == bus.rd_addr[k*ADDR_W +: ADDR_W]))
                    rd_data_c[k*DATA_W +: DATA_W] = bus.wr0_data;
                if (bus.wr1_en && (bus.wr1_addr == bus.rd_addr[k*ADDR_W +: ADDR_W]))
                    rd_data_c[k*DATA_W +: DATA_W] = bus.wr1_data;
            end
        end
    end

    logic clash_set;
    logic drop_set;
    logic wr_clash;
    logic wr_drop;

    assign clash_set = ready && bus.wr0_en && bus.wr1_en && (bus.wr0_addr == bus.wr1_addr);
    assign drop_set  = !ready && (bus.wr0_en || bus.wr1_en);

    // A set in the same cycle as err_clr wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_clash <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            wr_clash <= clash_set || (wr_clash && !bus.err_clr);
            wr_drop  <= drop_set  || (wr_drop  && !bus.err_clr);
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.ready    = ready;
    assign bus.wr_clash = wr_clash;
    assign bus.wr_drop  = wr_drop;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed reset/clear, bypass, clash and drop cases on a
// BYPASS=1 and a BYPASS=0 instance, then random traffic against an array model.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int RP = 3;
    localparam int NR = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) bus    ();
    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) bus_nb ();

    assign bus_nb.rd_addr  = bus.rd_addr;
    assign bus_nb.wr0_en   = bus.wr0_en;
    assign bus_nb.wr0_addr = bus.wr0_addr;
    assign bus_nb.wr0_data = bus.wr0_data;
    assign bus_nb.wr1_en   = bus.wr1_en;
    assign bus_nb.wr1_addr = bus.wr1_addr;
    assign bus_nb.wr1_data = bus.wr1_data;
    assign bus_nb.err_clr  = bus.err_clr;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP), .BYPASS(1), .CLEAR_ON_RESET(1))
        dut (.clk(clk), .rst(rst), .bus(bus));

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP), .BYPASS(0), .CLEAR_ON_RESET(1))
        dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model [NR];
    logic          exp_clash;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.wr0_en   = e0;
        bus.wr0_addr = a0;
        bus.wr0_data = d0;
        bus.wr1_en   = e1;
        bus.wr1_addr = a1;
        bus.wr1_data = d1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        bus.err_clr = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bus.rd_addr = {r2, r1, r0};
        #1;
    endtask

    function automatic logic [DW-1:0] rd_of(input logic [RP*DW-1:0] v, input int k);
        return v[k*DW +: DW];
    endfunction

    // Pulse rst for one edge, then count sampled cycles with ready low (bounded).
    task automatic reset_and_count(output int cycles);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cycles = 0;
        while (bus.ready !== 1'b1 && cycles < 64) begin
            cycles++;
            tick();
        end
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (bus.ready !== 1'b1 && guard < 64) begin
            guard++;
            tick();
        end
        check("wait_ready", {63'd0, bus.ready}, 64'd1);
    endtask

    initial begin
        int cyc;
        logic          e0, e1, clr;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1, exp_b;
        logic [AW-1:0] ra [RP];

        idle();
        bus.rd_addr = '0;

        // Initial reset: flags and ready low straight after the reset edge.
        rst = 1'b1;
        tick();
        tick();
        check("rst_ready",    {63'd0, bus.ready},    64'd0);
        check("rst_clash",    {63'd0, bus.wr_clash}, 64'd0);
        check("rst_drop",     {63'd0, bus.wr_drop},  64'd0);
        rst = 1'b0;
        wait_ready();

        // 1. Pre-fill with DEADBEEF, pulse reset, expect 16 not-ready cycles and a zeroed file.
        for (int r = 0; r < NR; r += 2) begin
            drive(1'b1, AW'(r), 32'hDEADBEEF, 1'b1, AW'(r + 1), 32'hDEADBEEF);
            tick();
        end
        idle();
        set_rd(4'd0, 4'd7, 4'd15);
        check("prefill_r0",  rd_of(bus.rd_data, 0), 32'hDEADBEEF);
        check("prefill_r15", rd_of(bus.rd_data, 2), 32'hDEADBEEF);
        reset_and_count(cyc);
        check("clear_cycles",    cyc, 16);
        check("clear_nb_ready",  {63'd0, bus_nb.ready}, 64'd1);
        for (int r = 0; r < NR; r++) begin
            set_rd(AW'(r), AW'(r), AW'(r));
            check("cleared_reg", rd_of(bus.rd_data, r % RP), 32'd0);
        end

        // 2. Basic write then read; other ports on r4.
        drive(1'b1, 4'd3, 32'h12345678, 1'b0, '0, '0);
        tick();
        idle();
        set_rd(4'd3, 4'd4, 4'd4);
        check("basic_r3",   rd_of(bus.rd_data, 0), 32'h12345678);
        check("basic_r4_1", rd_of(bus.rd_data, 1), 32'd0);
        check("basic_r4_2", rd_of(bus.rd_data, 2), 32'd0);

        // 3. Same-cycle bypass on port 1, and none on the BYPASS=0 instance.
        set_rd(4'd0, 4'd5, 4'd0);
        drive(1'b1, 4'd5, 32'hA5A5A5A5, 1'b0, '0, '0);
        #1;
        check("bypass_on",  rd_of(bus.rd_data, 1),    32'hA5A5A5A5);
        check("bypass_off", rd_of(bus_nb.rd_data, 1), 32'd0);
        tick();
        idle();
        #1;
        check("bypass_off_after", rd_of(bus_nb.rd_data, 1), 32'hA5A5A5A5);

        // 4. Clash on r7: port 1 wins, sticky flag, cleared by err_clr.
        set_rd(4'd7, 4'd7, 4'd7);
        drive(1'b1, 4'd7, 32'h1, 1'b1, 4'd7, 32'h2);
        #1;
        check("clash_bypass", rd_of(bus.rd_data, 2), 32'h2);
        tick();
        idle();
        #1;
        check("clash_flag", {63'd0, bus.wr_clash}, 64'd1);
        check("clash_r7",   rd_of(bus.rd_data, 0), 32'h2);
        tick();
        check("clash_sticky", {63'd0, bus.wr_clash}, 64'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("clash_cleared", {63'd0, bus.wr_clash}, 64'd0);

        // Clash in the same cycle as err_clr: the set wins.
        drive(1'b1, 4'd8, 32'h8, 1'b1, 4'd8, 32'h9);
        bus.err_clr = 1'b1;
        tick();
        idle();
        check("clash_set_dominates", {63'd0, bus.wr_clash}, 64'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;

        // 5. Disjoint dual write.
        drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        tick();
        idle();
        set_rd(4'd1, 4'd2, 4'd8);
        check("disjoint_r1",    rd_of(bus.rd_data, 0), 32'h11);
        check("disjoint_r2",    rd_of(bus.rd_data, 1), 32'h22);
        check("disjoint_r8",    rd_of(bus.rd_data, 2), 32'h9);
        check("disjoint_clash", {63'd0, bus.wr_clash}, 64'd0);

        // 6a. Write during clear cycle 3 is dropped; a drop with err_clr still sets the flag.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        drive(1'b1, 4'd0, 32'hFF, 1'b0, '0, '0);
        tick();
        idle();
        check("drop_flag",  {63'd0, bus.wr_drop}, 64'd1);
        check("drop_ready", {63'd0, bus.ready},   64'd0);
        drive(1'b0, '0, '0, 1'b1, 4'd9, 32'h99);
        bus.err_clr = 1'b1;
        tick();
        idle();
        check("drop_set_dominates", {63'd0, bus.wr_drop}, 64'd1);
        wait_ready();
        set_rd(4'd0, 4'd9, 4'd0);
        check("drop_r0", rd_of(bus.rd_data, 0), 32'd0);
        check("drop_r9", rd_of(bus.rd_data, 1), 32'd0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("drop_cleared", {63'd0, bus.wr_drop}, 64'd0);

        // 6b. Reset at clear cycle 8 restarts the full 16-cycle clear.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("midclear_not_ready", {63'd0, bus.ready}, 64'd0);
        reset_and_count(cyc);
        check("midclear_cycles", cyc, 16);

        // Random traffic against the array model; file is all zero here.
        for (int r = 0; r < NR; r++) model[r] = '0;
        exp_clash = 1'b0;
        for (int it = 0; it < 400; it++) begin
            e0  = 1'($urandom_range(0, 1));
            e1  = 1'($urandom_range(0, 1));
            a0  = AW'($urandom_range(0, NR - 1));
            a1  = AW'($urandom_range(0, NR - 1));
            d0  = $urandom;
            d1  = $urandom;
            clr = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < RP; k++) ra[k] = AW'($urandom_range(0, NR - 1));
            drive(e0, a0, d0, e1, a1, d1);
            bus.err_clr = clr;
            set_rd(ra[0], ra[1], ra[2]);
            for (int k = 0; k < RP; k++) begin
                exp_b = model[ra[k]];
                if (e0 && a0 == ra[k]) exp_b = d0;
                if (e1 && a1 == ra[k]) exp_b = d1;
                check("rand_rd_bypass", rd_of(bus.rd_data, k),    exp_b);
                check("rand_rd_array",  rd_of(bus_nb.rd_data, k), model[ra[k]]);
            end
            tick();
            if (e0) model[a0] = d0;
            if (e1) model[a1] = d1;
            if (e0 && e1 && a0 == a1) exp_clash = 1'b1;
            else if (clr)             exp_clash = 1'b0;
            check("rand_clash", {63'd0, bus.wr_clash}, {63'd0, exp_clash});
            check("rand_drop",  {63'd0, bus.wr_drop},  64'd0);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
